// File: rtl/mem_line_ctrl_pkg.sv
// Shared definitions for the cache line-transfer path: widths, address
// field split, and the line controller state encoding.
package mem_line_ctrl_pkg;

  localparam int LINE_W   = 512;
  localparam int WORD_W   = 32;
  localparam int BEATS    = LINE_W / WORD_W;
  localparam int TAG_W    = 19;
  localparam int INDEX_W  = 7;
  localparam int OFFSET_W = 6;
  localparam int LADDR_W  = 32 - OFFSET_W;   // line-aligned address bits
  localparam int BEAT_W   = 4;
  localparam int CAP_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BEAT  = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_DRAIN = 3'd3,
    ST_RESP     = 3'd4
  } mlc_state_e;

  // Byte address of word k inside a line: {line address, k, 2'b00}.
  function automatic logic [31:0] beat_addr(input logic [LADDR_W-1:0] line_a,
                                            input logic [BEAT_W-1:0]  k);
    return {line_a, k, 2'b00};
  endfunction

endpackage

// File: rtl/mem_line_ctrl_rd_return_pipe.sv
// Fixed-latency read return tracker: a RD_LAT-deep shift of {valid, beat
// index}. The output stage lines up with the cycle in which memory presents
// the word for that beat, so it doubles as the capture strobe and slot index.
module rd_return_pipe
  import mem_line_ctrl_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [BEAT_W-1:0] in_idx_i,
  output logic              cap_valid_o,
  output logic [BEAT_W-1:0] cap_idx_o
);

  logic              vld_q [RD_LAT];
  logic [BEAT_W-1:0] idx_q [RD_LAT];

  // Shift beat tags one stage per cycle; reset empties the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid_i;
      idx_q[0] <= in_idx_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign cap_valid_o = vld_q[RD_LAT-1];
  assign cap_idx_o   = idx_q[RD_LAT-1];

endmodule

// File: rtl/mem_line_ctrl.sv
// Line-transfer controller: moves one 512-bit cache line to or from word-wide
// memory as 16 sequential beats. All outputs come straight from registers
// whose next values are derived from the next state.
module mem_line_ctrl
  import mem_line_ctrl_pkg::*;
#(
  parameter int LINE_W = mem_line_ctrl_pkg::LINE_W,
  parameter int WORD_W = mem_line_ctrl_pkg::WORD_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_W / WORD_W - 1);
  localparam logic [CAP_W-1:0]  CAP_DONE  = CAP_W'(LINE_W / WORD_W);

  mlc_state_e          state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CAP_W-1:0]    cap_q, cap_d;
  logic [LADDR_W-1:0]  laddr_q, laddr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                resp_valid_q, resp_valid_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                cap_valid_s;
  logic [BEAT_W-1:0]   cap_idx_s;
  logic                cap_en_s;
  logic                unused_offset_s;

  // Offset bits of the request address are ignored: transfers are line-aligned.
  assign unused_offset_s = ^req_addr[OFFSET_W-1:0];

  rd_return_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_return_pipe (
    .clk         (clk),
    .rst_n       (rst),
    .in_valid_i  (state_q == ST_RD_ISSUE),
    .in_idx_i    (beat_q),
    .cap_valid_o (cap_valid_s),
    .cap_idx_o   (cap_idx_s)
  );

  assign cap_en_s = cap_valid_s &&
                    ((state_q == ST_RD_ISSUE) || (state_q == ST_RD_DRAIN));

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    cap_d        = cap_q;
    laddr_d      = laddr_q;
    line_d       = line_q;
    resp_rdata_d = resp_rdata_q;

    // Returning read words land in their slot as they arrive.
    if (cap_en_s) begin
      line_d[int'(cap_idx_s)*WORD_W +: WORD_W] = mem_rdata;
      cap_d = cap_q + 5'd1;
    end else begin
      cap_d = cap_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          laddr_d = req_addr[31:OFFSET_W];
          line_d  = req_wdata;
          beat_d  = 4'd0;
          cap_d   = 5'd0;
          state_d = req_write ? ST_WR_BEAT : ST_RD_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_BEAT: begin
        beat_d = beat_q + 4'd1;
        if (beat_q == LAST_BEAT) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WR_BEAT;
        end
      end
      ST_RD_ISSUE: begin
        beat_d = beat_q + 4'd1;
        if (beat_q == LAST_BEAT) begin
          state_d = ST_RD_DRAIN;
        end else begin
          state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_DRAIN: begin
        // Leave as soon as the final word is being captured this cycle.
        if (cap_d == CAP_DONE) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_RD_DRAIN;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Publish the assembled line only when a read completes.
    if ((state_d == ST_RESP) && (state_q == ST_RD_DRAIN)) begin
      resp_rdata_d = line_d;
    end else begin
      resp_rdata_d = resp_rdata_q;
    end

    req_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);

    // Memory port reflects the beat that will be current next cycle.
    if ((state_d == ST_WR_BEAT) || (state_d == ST_RD_ISSUE)) begin
      mem_en_d   = 1'b1;
      mem_we_d   = (state_d == ST_WR_BEAT);
      mem_addr_d = beat_addr(laddr_d, beat_d);
      if (state_d == ST_WR_BEAT) begin
        mem_wdata_d = line_d[int'(beat_d)*WORD_W +: WORD_W];
      end else begin
        mem_wdata_d = '0;
      end
    end else begin
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = 32'd0;
      mem_wdata_d = '0;
    end
  end

  // State, datapath and output registers; reset abandons any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= 4'd0;
      cap_q        <= 5'd0;
      laddr_q      <= '0;
      line_q       <= '0;
      resp_rdata_q <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      cap_q        <= cap_d;
      laddr_q      <= laddr_d;
      line_q       <= line_d;
      resp_rdata_q <= resp_rdata_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed bench for mem_line_ctrl. Three instances share clock and reset:
// index 0 uses RD_LAT=2 (main tests), 1 uses RD_LAT=1, 2 uses RD_LAT=4.
// Each has a fixed-latency memory model returning base+k for word k.
module tb_mem_line_ctrl;

  logic         clk;
  logic         rst;
  logic [2:0]   req_valid_a;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [511:0] req_wdata;
  logic [31:0]  rd_base;

  logic [2:0]   req_ready_a, resp_valid_a, busy_a, mem_en_a, mem_we_a;
  logic [511:0] resp_rdata_a [3];
  logic [31:0]  mem_addr_a [3];
  logic [31:0]  mem_wdata_a [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic         req_ready_s, resp_valid_s, busy_s, mem_en_s, mem_we_s;
    logic [511:0] resp_rdata_s;
    logic [31:0]  mem_addr_s, mem_wdata_s, mem_rdata_s;
    logic         sh_v [4];
    logic [31:0]  sh_d [4];

    mem_line_ctrl #(.LINE_W(512), .WORD_W(32), .RD_LAT(L)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid_a[g]),
      .req_ready  (req_ready_s),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid_s),
      .resp_rdata (resp_rdata_s),
      .busy       (busy_s),
      .mem_en     (mem_en_s),
      .mem_we     (mem_we_s),
      .mem_addr   (mem_addr_s),
      .mem_wdata  (mem_wdata_s),
      .mem_rdata  (mem_rdata_s)
    );

    // Memory model: word for the read beat of cycle c is driven during c+L.
    initial begin
      for (int i = 0; i < 4; i++) begin
        sh_v[i] = 1'b0;
        sh_d[i] = 32'd0;
      end
      mem_rdata_s = 32'hDEAD_BEEF;
    end
    always @(negedge clk) begin
      sh_v[0] <= mem_en_s && !mem_we_s;
      sh_d[0] <= rd_base + {28'd0, mem_addr_s[5:2]};
      for (int i = 1; i < 4; i++) begin
        sh_v[i] <= sh_v[i-1];
        sh_d[i] <= sh_d[i-1];
      end
      mem_rdata_s <= sh_v[L-1] ? sh_d[L-1] : 32'hDEAD_BEEF;
    end

    assign req_ready_a[g]  = req_ready_s;
    assign resp_valid_a[g] = resp_valid_s;
    assign busy_a[g]       = busy_s;
    assign mem_en_a[g]     = mem_en_s;
    assign mem_we_a[g]     = mem_we_s;
    assign resp_rdata_a[g] = resp_rdata_s;
    assign mem_addr_a[g]   = mem_addr_s;
    assign mem_wdata_a[g]  = mem_wdata_s;
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 512'(req_ready_a[0]), 512'(1'b1));
    check_eq({tag, "_busy"},  512'(busy_a[0]), 512'(1'b0));
    check_eq({tag, "_resp"},  512'(resp_valid_a[0]), 512'(1'b0));
    check_eq({tag, "_rdata"}, resp_rdata_a[0], 512'd0);
    check_eq({tag, "_en"},    512'(mem_en_a[0]), 512'(1'b0));
    check_eq({tag, "_we"},    512'(mem_we_a[0]), 512'(1'b0));
    check_eq({tag, "_addr"},  512'(mem_addr_a[0]), 512'd0);
    check_eq({tag, "_wdata"}, 512'(mem_wdata_a[0]), 512'd0);
  endtask

  // Present one request to the instances in mask; returns after the accept edge.
  task automatic issue(input logic [2:0] mask, input logic wr, input logic [31:0] addr,
                       input logic [511:0] wdata, input string tag);
    @(negedge clk);
    req_valid_a = mask;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wdata;
    check_eq({tag, "_acc_ready"}, 512'(req_ready_a[0]), 512'(1'b1));
    @(posedge clk);
    #1;
    req_valid_a = 3'b000;
    req_wdata   = '0;
  endtask

  // Follow a read on instance 0 from cycle 1 after its accept.
  task automatic observe_read(input logic [31:0] line_addr, input logic [31:0] dbase,
                              input string tag);
    int resp_n;
    resp_n = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n <= 16) begin
        check_eq({tag, "_en"},   512'(mem_en_a[0]), 512'(1'b1));
        check_eq({tag, "_we"},   512'(mem_we_a[0]), 512'(1'b0));
        check_eq({tag, "_addr"}, 512'(mem_addr_a[0]), 512'(line_addr + 32'(4*(n-1))));
      end
      if (resp_valid_a[0]) begin
        resp_n = n;
        break;
      end
    end
    check_eq({tag, "_resp_cycle"}, 512'(resp_n), 512'(19));
    check_eq({tag, "_line"}, resp_rdata_a[0], mk_line(dbase));
    check_eq({tag, "_w0"},  512'(resp_rdata_a[0][31:0]), 512'(dbase));
    check_eq({tag, "_w15"}, 512'(resp_rdata_a[0][511:480]), 512'(dbase + 32'd15));
    @(negedge clk);
    check_eq({tag, "_pulse_end"}, 512'(resp_valid_a[0]), 512'(1'b0));
    check_eq({tag, "_ready_back"}, 512'(req_ready_a[0]), 512'(1'b1));
  endtask

  initial begin
    int resp_n [3];
    int seen;
    rst = 1'b0;
    req_valid_a = 3'b000;
    req_write = 1'b0;
    req_addr = 32'd0;
    req_wdata = '0;
    rd_base = 32'hB000_0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;

    // Write with req_valid held: second request (a read) accepted in cycle 18.
    @(negedge clk);
    req_valid_a = 3'b001;
    req_write   = 1'b1;
    req_addr    = 32'h0000_2040;
    req_wdata   = mk_line(32'hA000_0000);
    check_eq("wr_acc_ready", 512'(req_ready_a[0]), 512'(1'b1));
    @(posedge clk);
    #1;
    req_write = 1'b0;
    req_addr  = 32'h0001_0000;
    req_wdata = '0;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      check_eq("wr_ready_low", 512'(req_ready_a[0]), 512'(1'b0));
      check_eq("wr_resp", 512'(resp_valid_a[0]), 512'(n == 17));
      if (n <= 16) begin
        check_eq("wr_en", 512'(mem_en_a[0]), 512'(1'b1));
        check_eq("wr_we", 512'(mem_we_a[0]), 512'(1'b1));
        check_eq("wr_addr", 512'(mem_addr_a[0]), 512'(32'h0000_2040 + 32'(4*(n-1))));
        check_eq("wr_wdata", 512'(mem_wdata_a[0]), 512'(32'hA000_0000 + 32'(n-1)));
      end else begin
        check_eq("wr_idle_en", 512'(mem_en_a[0]), 512'(1'b0));
        check_eq("wr_idle_addr", 512'(mem_addr_a[0]), 512'd0);
      end
    end
    @(negedge clk);
    check_eq("wr_c18_ready", 512'(req_ready_a[0]), 512'(1'b1));
    check_eq("wr_c18_busy", 512'(busy_a[0]), 512'(1'b0));
    check_eq("wr_c18_rdata", resp_rdata_a[0], 512'd0);
    @(posedge clk);
    #1;
    req_valid_a = 3'b000;
    observe_read(32'h0001_0000, 32'hB000_0000, "rd");

    // Offset bits set: same beat addresses as the aligned request.
    rd_base = 32'hD000_0000;
    issue(3'b001, 1'b0, 32'h0001_003F, '0, "rdoff");
    observe_read(32'h0001_0000, 32'hD000_0000, "rdoff");

    // Write must leave resp_rdata untouched.
    issue(3'b001, 1'b1, 32'h0000_3000, mk_line(32'h1111_0000), "wrhold");
    seen = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (resp_valid_a[0]) begin
        seen = n;
        break;
      end
    end
    check_eq("wrhold_resp_cycle", 512'(seen), 512'(17));
    check_eq("wrhold_rdata", resp_rdata_a[0], mk_line(32'hD000_0000));

    // Reset in cycle 8 of a read.
    rd_base = 32'hE000_0000;
    issue(3'b001, 1'b0, 32'h0004_0000, '0, "rdrst");
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (resp_valid_a[0] || busy_a[0]) seen++;
    end
    check_eq("midrst_quiet", 512'(seen), 512'd0);
    rd_base = 32'hC000_0000;
    issue(3'b001, 1'b0, 32'h0008_0000, '0, "rdpost");
    observe_read(32'h0008_0000, 32'hC000_0000, "rdpost");

    // Same read on all three latency builds.
    rd_base = 32'hB000_0000;
    issue(3'b111, 1'b0, 32'h0001_0000, '0, "lat");
    for (int g = 0; g < 3; g++) resp_n[g] = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (resp_valid_a[g] && (resp_n[g] < 0)) resp_n[g] = n;
      end
    end
    check_eq("lat2_cycle", 512'(resp_n[0]), 512'(19));
    check_eq("lat1_cycle", 512'(resp_n[1]), 512'(18));
    check_eq("lat4_cycle", 512'(resp_n[2]), 512'(21));
    check_eq("lat2_line", resp_rdata_a[0], mk_line(32'hB000_0000));
    check_eq("lat1_line", resp_rdata_a[1], mk_line(32'hB000_0000));
    check_eq("lat4_line", resp_rdata_a[2], mk_line(32'hB000_0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
